// File: rtl/dbg_monitor.sv
// dbg_monitor: sticky handshake flags, saturating event counters and address-match capture units,
// all read through a one-cycle-latency register port. Define DBG_MONITOR_TIMESTAMP_EN for first-valid timestamps.
// Capture FSM:  state | meaning
//   IDLE  | not armed, monitored writes ignored
//   ARMED | waiting for a write to the match address
//   DONE  | one-shot hit taken, data held until re-armed
module dbg_monitor #(
  parameter int          NUM_CH    = 8,
  parameter int          CNT_W     = 32,
  parameter int          NUM_CAP   = 2,
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 16,
  parameter int          RD_ADDR_W = 8,
  parameter logic [31:0] MAGIC     = 32'd16032003
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         vld_i,
  input  logic [NUM_CH-1:0]         rdy_i,
  input  logic                      clear_i,
  input  logic                      freeze_i,
  input  logic                      mon_en_i,
  input  logic [ADDR_W-1:0]         mon_addr_i,
  input  logic [DATA_W-1:0]         mon_data_i,
  input  logic [NUM_CAP*ADDR_W-1:0] cap_match_i,
  input  logic [NUM_CAP-1:0]        cap_arm_i,
  input  logic [NUM_CAP-1:0]        cap_cont_i,
  input  logic                      rd_req_i,
  input  logic [RD_ADDR_W-1:0]      rd_addr_i,
  output logic                      rd_vld_o,
  output logic [31:0]               rd_data_o
);

  localparam int B = 4 + NUM_CH;
`ifdef DBG_MONITOR_TIMESTAMP_EN
  localparam int N_WORDS = B + 2*NUM_CAP + NUM_CH;
`else
  localparam int N_WORDS = B + 2*NUM_CAP;
`endif

  if (N_WORDS > (1 << RD_ADDR_W)) begin : g_bad_params
    $error("dbg_monitor: register map does not fit in RD_ADDR_W");
  end

  typedef enum logic [1:0] {
    CAP_IDLE  = 2'd0,
    CAP_ARMED = 2'd1,
    CAP_DONE  = 2'd2
  } cap_state_t;

  logic [NUM_CH-1:0]  vld_flag, rdy_flag;
  logic [CNT_W-1:0]   cnt [NUM_CH];
  cap_state_t         cap_state [NUM_CAP];
  cap_state_t         cap_state_nxt [NUM_CAP];
  logic [DATA_W-1:0]  cap_data [NUM_CAP];
  logic [DATA_W-1:0]  cap_data_nxt [NUM_CAP];
  logic [15:0]        hit_cnt [NUM_CAP];
  logic [15:0]        hit_cnt_nxt [NUM_CAP];
  logic [NUM_CAP-1:0] cap_trig;
  logic [31:0]        rd_mux;

  // rst_n is active high; clear shares the reset path, freeze gates every update
  always_ff @(posedge clk) begin
    if (rst_n || clear_i) begin
      vld_flag <= '0;
      rdy_flag <= '0;
      for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
    end else if (!freeze_i) begin
      vld_flag <= vld_flag | vld_i;
      rdy_flag <= rdy_flag | rdy_i;
      for (int c = 0; c < NUM_CH; c++) begin
        if (vld_i[c] && (cnt[c] != '1)) cnt[c] <= cnt[c] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    cap_trig = '0;
    for (int k = 0; k < NUM_CAP; k++) begin
      cap_state_nxt[k] = cap_state[k];
      cap_data_nxt[k]  = cap_data[k];
      hit_cnt_nxt[k]   = hit_cnt[k];
      cap_trig[k]      = mon_en_i && (mon_addr_i == cap_match_i[k*ADDR_W +: ADDR_W]);
      unique case (cap_state[k])
        CAP_IDLE: begin
          if (cap_arm_i[k]) cap_state_nxt[k] = CAP_ARMED;
        end
        CAP_ARMED: begin
          if (cap_trig[k]) begin
            cap_data_nxt[k] = mon_data_i;
            if (hit_cnt[k] != 16'hffff) hit_cnt_nxt[k] = hit_cnt[k] + 16'd1;
            if (!cap_cont_i[k]) cap_state_nxt[k] = CAP_DONE;
          end
        end
        CAP_DONE: begin
          if (cap_arm_i[k]) cap_state_nxt[k] = CAP_ARMED;
        end
        default: cap_state_nxt[k] = CAP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CAP; k++) begin
      if (rst_n || clear_i) begin
        cap_state[k] <= CAP_IDLE;
        cap_data[k]  <= '0;
        hit_cnt[k]   <= '0;
      end else if (!freeze_i) begin
        cap_state[k] <= cap_state_nxt[k];
        cap_data[k]  <= cap_data_nxt[k];
        hit_cnt[k]   <= hit_cnt_nxt[k];
      end
    end
  end

`ifdef DBG_MONITOR_TIMESTAMP_EN
  logic [31:0] cyc_cnt;
  logic [31:0] ts [NUM_CH];

  // free-running: only reset stops it, so timestamps stay comparable across clears
  always_ff @(posedge clk) begin
    if (rst_n) cyc_cnt <= '0;
    else       cyc_cnt <= cyc_cnt + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst_n || clear_i) begin
      for (int c = 0; c < NUM_CH; c++) ts[c] <= '0;
    end else if (!freeze_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (vld_i[c] && !vld_flag[c]) ts[c] <= cyc_cnt;
      end
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    if (int'(rd_addr_i) == 0) rd_mux = MAGIC;
    if (int'(rd_addr_i) == 1) rd_mux = {8'(NUM_CAP), 8'(NUM_CH), 16'(CNT_W)};
    if (int'(rd_addr_i) == 2) rd_mux = 32'(vld_flag);
    if (int'(rd_addr_i) == 3) rd_mux = 32'(rdy_flag);
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(rd_addr_i) == 4 + c) rd_mux = 32'(cnt[c]);
    end
    for (int k = 0; k < NUM_CAP; k++) begin
      if (int'(rd_addr_i) == B + 2*k)     rd_mux = 32'(cap_data[k]);
      if (int'(rd_addr_i) == B + 2*k + 1) rd_mux = {cap_state[k], 14'b0, hit_cnt[k]};
    end
`ifdef DBG_MONITOR_TIMESTAMP_EN
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(rd_addr_i) == B + 2*NUM_CAP + c) rd_mux = ts[c];
    end
`endif
  end

  // read data is sampled from pre-update state, so it reflects the end of the request cycle
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rd_vld_o  <= 1'b0;
      rd_data_o <= '0;
    end else begin
      rd_vld_o <= rd_req_i;
      if (rd_req_i) rd_data_o <= rd_mux;
    end
  end

endmodule

// File: tb/tb_dbg_monitor.sv
// Directed bench for dbg_monitor: reads are scoreboarded when requested and checked when rd_vld_o returns.
// A second instance with CNT_W=4 shares the stimulus to exercise counter saturation.
module tb_dbg_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  vld, rdy;
  logic        clear, freeze, mon_en;
  logic [15:0] mon_addr;
  logic [31:0] mon_data;
  logic [31:0] cap_match;
  logic [1:0]  cap_arm, cap_cont;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic        rd_vld, rd_vld4;
  logic [31:0] rd_data, rd_data4;
  logic        req_d = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp4_q[$];
  bit          chk4_q[$];

  always #5 clk = ~clk;

  dbg_monitor dut (
    .clk(clk), .rst_n(rst_n), .vld_i(vld), .rdy_i(rdy), .clear_i(clear), .freeze_i(freeze),
    .mon_en_i(mon_en), .mon_addr_i(mon_addr), .mon_data_i(mon_data), .cap_match_i(cap_match),
    .cap_arm_i(cap_arm), .cap_cont_i(cap_cont), .rd_req_i(rd_req), .rd_addr_i(rd_addr),
    .rd_vld_o(rd_vld), .rd_data_o(rd_data)
  );

  dbg_monitor #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .vld_i(vld), .rdy_i(rdy), .clear_i(clear), .freeze_i(freeze),
    .mon_en_i(mon_en), .mon_addr_i(mon_addr), .mon_data_i(mon_data), .cap_match_i(cap_match),
    .cap_arm_i(cap_arm), .cap_cont_i(cap_cont), .rd_req_i(rd_req), .rd_addr_i(rd_addr),
    .rd_vld_o(rd_vld4), .rd_data_o(rd_data4)
  );

  always @(posedge clk) req_d <= rd_req && !rst_n;

  always @(negedge clk) begin
    if (rd_vld === 1'b1 || req_d) begin
      vectors++;
      assert (rd_vld === req_d) else begin
        miscompares++;
        $error("FAIL rd_vld_timing: got %b expected %b", rd_vld, req_d);
      end
    end
    if (rd_vld === 1'b1) begin
      if (tag_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_read: got data %h expected no response", rd_data);
      end else begin
        string t;
        logic [31:0] e, e4;
        bit c4;
        t = tag_q.pop_front(); e = exp_q.pop_front(); e4 = exp4_q.pop_front(); c4 = chk4_q.pop_front();
        vectors++;
        assert (rd_data === e) else begin
          miscompares++;
          $error("FAIL %s: got %h expected %h", t, rd_data, e);
        end
        if (c4) begin
          vectors++;
          assert (rd_data4 === e4) else begin
            miscompares++;
            $error("FAIL %s_cnt4: got %h expected %h", t, rd_data4, e4);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input int a, input string tag, input logic [31:0] e,
                    input bit c4 = 1'b0, input logic [31:0] e4 = 32'h0);
    rd_req  = 1'b1;
    rd_addr = 8'(a);
    tag_q.push_back(tag); exp_q.push_back(e); exp4_q.push_back(e4); chk4_q.push_back(c4);
    step(1);
    rd_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (tag_q.size() != 0 && n < 8) begin
      step(1);
      n++;
    end
    vectors++;
    assert (tag_q.size() == 0) else begin
      miscompares++;
      $error("FAIL drain: got %0d reads pending expected 0", tag_q.size());
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    mon_en = 1'b1; mon_addr = a; mon_data = d;
    step(1);
    mon_en = 1'b0;
  endtask

  task automatic arm(input logic [1:0] m);
    cap_arm = m;
    step(1);
    cap_arm = 2'b00;
  endtask

  initial begin
    logic [31:0] ts_exp;
    rst_n = 1'b1; vld = '0; rdy = '0; clear = 1'b0; freeze = 1'b0; mon_en = 1'b0;
    mon_addr = '0; mon_data = '0; cap_match = {16'd20, 16'd10}; cap_arm = '0; cap_cont = '0;
    rd_req = 1'b0; rd_addr = '0;
    step(3);
    vectors++;
    assert (rd_vld === 1'b0 && rd_data === 32'h0) else begin
      miscompares++;
      $error("FAIL reset_rd: got vld %b data %h expected 0/0", rd_vld, rd_data);
    end
    rst_n = 1'b0;

    rd(0, "magic", 32'd16032003, 1'b1, 32'd16032003);
    rd(1, "params", 32'h0208_0020, 1'b1, 32'h0208_0004);
    drain();
    step(2);
    vectors++;
    assert (rd_vld === 1'b0 && rd_data === 32'h0208_0020) else begin
      miscompares++;
      $error("FAIL rd_hold: got vld %b data %h expected 0/02080020", rd_vld, rd_data);
    end

    // sticky flags, counter, and read-before-update ordering
    vld = 8'h08; step(5); vld = '0;
    rdy = 8'h01; step(1); rdy = '0;
    rd(2, "vld_flags", 32'h08);
    rd(3, "rdy_flags", 32'h01);
    rd(4, "cnt0_idle", 32'd0, 1'b1, 32'd0);
    vld = 8'h08; rd(7, "cnt3_pre", 32'd5, 1'b1, 32'd5); vld = '0;
    rd(7, "cnt3_post", 32'd6, 1'b1, 32'd6);
    clear = 1'b1; step(1); clear = 1'b0;
    rd(2, "vld_clr", 32'h0);
    rd(3, "rdy_clr", 32'h0);
    rd(7, "cnt3_clr", 32'h0, 1'b1, 32'h0);
    drain();

    vld = 8'h01; step(20); vld = '0;
    rd(4, "cnt0_sat", 32'd20, 1'b1, 32'd15);
    drain();

    // one-shot capture
    arm(2'b01);
    rd(13, "cap0_armed", 32'h4000_0000);
    wr(16'd11, 32'h55);
    wr(16'd10, 32'hAB);
    wr(16'd10, 32'hCD);
    wr(16'd20, 32'h77);
    rd(12, "cap0_data_1s", 32'hAB);
    rd(13, "cap0_stat_1s", 32'h8000_0001);
    rd(14, "cap1_idle_data", 32'h0);
    rd(15, "cap1_idle_stat", 32'h0);
    arm(2'b01);
    rd(13, "cap0_rearm", 32'h4000_0001);
    rd(12, "cap0_rearm_data", 32'hAB);
    clear = 1'b1; step(1); clear = 1'b0;
    rd(12, "cap0_clr_data", 32'h0);
    rd(13, "cap0_clr_stat", 32'h0);
    drain();

    // continuous capture
    cap_cont = 2'b01;
    arm(2'b01);
    wr(16'd10, 32'hAB);
    wr(16'd10, 32'hCD);
    rd(12, "cap0_data_cont", 32'hCD);
    rd(13, "cap0_stat_cont", 32'h4000_0002);
    drain();

    // freeze blocks every update but still serves reads
    freeze = 1'b1; vld = 8'h02; mon_en = 1'b1; mon_addr = 16'd10; mon_data = 32'hEE; cap_arm = 2'b10;
    step(1);
    vld = '0; mon_en = 1'b0; cap_arm = '0;
    rd(5, "cnt1_frz_rd", 32'h0);
    freeze = 1'b0;
    rd(5, "cnt1_frz", 32'h0);
    rd(2, "vld_frz", 32'h0);
    rd(12, "cap0_frz_data", 32'hCD);
    rd(13, "cap0_frz_stat", 32'h4000_0002);
    rd(15, "cap1_frz_stat", 32'h0);
    drain();

    vld = 8'h04; step(1); vld = '0;
    rd(6, "cnt2_one", 32'd1);
    clear = 1'b1; vld = 8'h04; step(1); clear = 1'b0; vld = '0;
    rd(6, "cnt2_clr_evt", 32'd0);
    rd(2, "vld_clr_evt", 32'd0);
    vld = 8'h04; step(1); vld = '0;
    rd(6, "cnt2_after", 32'd1);
    rd(2, "vld_after", 32'h04);
    drain();

    // first-valid timestamp for channel 5 at cycles 100 and 150 after reset
    cap_cont = '0;
    rst_n = 1'b1; step(1); rst_n = 1'b0;
    step(100);
    vld = 8'h20; step(1); vld = '0;
    step(49);
    vld = 8'h20; step(1); vld = '0;
`ifdef DBG_MONITOR_TIMESTAMP_EN
    ts_exp = 32'd100;
`else
    ts_exp = 32'd0;
`endif
    rd(21, "ts5", ts_exp, 1'b1, ts_exp);
    rd(9, "cnt5_ts", 32'd2);
    drain();

    // reset in the same cycle as a request drops it
    rd_req = 1'b1; rd_addr = 8'd0; rst_n = 1'b1;
    step(1);
    rd_req = 1'b0;
    vectors++;
    assert (rd_vld === 1'b0 && rd_data === 32'h0) else begin
      miscompares++;
      $error("FAIL rst_mid_read: got vld %b data %h expected 0/0", rd_vld, rd_data);
    end
    rst_n = 1'b0;
    step(2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dbg_monitor.md
# dbg_monitor

Parametrised debug monitor: the next-generation debug block for the GAT accelerator. It records sticky valid/ready flags and saturating event counts for NUM_CH pipeline handshake channels (SPMM, DMVM, softmax, aggregation, …). It also runs NUM_CAP armable address-match capture units on a monitored BRAM write port. All state is exposed through a one-cycle-latency register read port, replacing fixed debug output buses.

## Interface
Parameters:
- NUM_CH, 8: monitored handshake channels.
- CNT_W, 32: per-channel event counter width (≤ 32).
- NUM_CAP, 2: capture units.
- DATA_W, 32: captured data width (≤ 32).
- ADDR_W, 16: monitored address width.
- RD_ADDR_W, 8: read-port address width.
- MAGIC, 16032003: constant returned at read address 0.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous, active-high reset despite the suffix; sampled on posedge clk.
- vld_i  in  NUM_CH  per-channel valid strobes.
- rdy_i  in  NUM_CH  per-channel ready strobes.
- clear_i  in  1  synchronous clear of flags, counters and captures.
- freeze_i  in  1  hold all monitor state; reads still served.
- mon_en_i  in  1  monitored port write enable.
- mon_addr_i  in  ADDR_W  monitored port address.
- mon_data_i  in  DATA_W  monitored port data.
- cap_match_i  in  NUM_CAP×ADDR_W  per-unit match address.
- cap_arm_i  in  NUM_CAP  per-unit arm pulse.
- cap_cont_i  in  NUM_CAP  per-unit continuous mode; 0 = one-shot.
- rd_req_i  in  1  read request.
- rd_addr_i  in  RD_ADDR_W  read address.
- rd_vld_o  out  1  read data valid.
- rd_data_o  out  32  read data.

## Operation
- Sticky flags: vld_flag[c] is set when vld_i[c]=1 and holds until clear/reset. rdy_flag[c] behaves the same for rdy_i[c].
- Counters: cnt[c] increments on each cycle with vld_i[c]=1. It saturates at 2^CNT_W−1 and never wraps.
- Capture unit k FSM:
  - IDLE → ARMED on cap_arm_i[k].
  - ARMED: trigger = mon_en_i && mon_addr_i==cap_match_i[k]. On trigger, cap_data[k] ← mon_data_i, hit_cnt[k] increments (saturating at 16 bits), and the unit moves to DONE if cap_cont_i[k]=0. If cap_cont_i[k]=1 it stays ARMED and overwrites on every hit.
  - DONE: holds data; cap_arm_i[k] re-arms (→ ARMED) without clearing data or hit_cnt.
  - Arm in ARMED is a no-op.
- Priority, highest first: rst_n > clear_i > freeze_i > normal update.
  - clear_i in the same cycle as an event: clear wins, and the event is lost.
  - freeze_i: no flag, counter, FSM or capture change; arm pulses are ignored.
- Read map (word addresses; unused/out-of-range addresses read 0):
  - 0: MAGIC.
  - 1: {8'(NUM_CAP), 8'(NUM_CH), 16'(CNT_W)}.
  - 2: vld flags, zero-extended.
  - 3: rdy flags, zero-extended.
  - 4..4+NUM_CH−1: cnt[c], zero-extended.
  - B=4+NUM_CH; B+2k: cap_data[k].
  - B+2k+1: {state[1:0] (0 IDLE, 1 ARMED, 2 DONE), 14'b0, hit_cnt[15:0]}.
  - Timestamp region: see Configuration.

## Timing
- Reset values: all flags, counters, cap_data, hit_cnt 0; FSMs IDLE; rd_vld_o=0; rd_data_o=0.
- Monitor updates are visible in state one cycle after the input strobe.
- Read latency 1: rd_req_i at cycle N gives rd_vld_o=1 and rd_data_o at N+1.
  - Data reflects state registered at the end of cycle N, before updates from cycle N inputs.
  - rd_vld_o is a single-cycle pulse per request; back-to-back reads are supported every cycle.
  - rd_data_o holds its last value when rd_vld_o=0.
- Reset mid-read: the pending read is dropped; rd_vld_o=0 in the next cycle.
- Parameter legality: 4+NUM_CH+2·NUM_CAP (+NUM_CH with timestamps) ≤ 2^RD_ADDR_W; elaboration-time assertion otherwise.

## Configuration
- DBG_MONITOR_TIMESTAMP_EN defined:
  - Adds a 32-bit free-running cycle counter, reset 0, wrapping, not affected by freeze_i or clear_i.
  - Adds ts[c], latched with the counter value on the first vld_i[c] after reset/clear, i.e. while vld_flag[c]=0.
  - ts[c] is readable at B+2·NUM_CAP+c.
- Undefined: no timestamp logic; those addresses read 0.

## Test plan
- Reset, then read addr 0 and 1 → 16032003 and {2,8,32}, each with rd_vld_o one cycle after rd_req_i.
- Pulse vld_i[3] for 5 cycles and rdy_i[0] once → addr 2 = 0x08, addr 3 = 0x01, addr 7 = 5; clear_i then gives 0 for all three.
- CNT_W=4, hold vld_i[0] for 20 cycles → addr 4 = 15 (saturated).
- Unit 0, one-shot, match 10: arm; write addr 10 data 0xAB, then addr 10 data 0xCD → cap_data 0xAB, hit_cnt 1, state DONE. With cap_cont_i=1 the same stimulus → 0xCD, hit_cnt 2, state ARMED.
- freeze_i high during a vld_i[1] pulse and a matching write → counters and captures unchanged; clear_i and vld_i[2] in the same cycle → cnt[2]=0.
- With DBG_MONITOR_TIMESTAMP_EN, vld_i[5] first at cycle 100 after reset and again at 150 → ts[5]=100. Without the macro, the same address reads 0.
